// File: rtl/oc_arb_pkg.sv
// rtl/oc_arb_pkg.sv - shared types, defaults and width helpers for the OC bus arbiter
package oc_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

  localparam int ARB_N        = 3;
  localparam int ARB_MAX_HOLD = 8;
  localparam int ARB_TA       = 1;

  // Bits needed for a counter that must reach max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n requesters (never less than one bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick
  import oc_arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int IW = idx_w(ARB_N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk positions ptr+N-1 down to ptr so the closest set bit at or after ptr wins last.
  always_comb begin
    int          pos;
    logic [IW-1:0] pos_i;
    pos    = 0;
    pos_i  = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      pos   = (int'(ptr) + k) % N;
      pos_i = IW'(pos);
      if (eligible[pos_i]) begin
        idx = pos_i;
        any = 1'b1;
      end
    end
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/oc_bus_arbiter.sv
// rtl/oc_bus_arbiter.sv - round-robin owner arbitration for a shared open-collector line
module oc_bus_arbiter
  import oc_arb_pkg::*;
#(
  parameter int N         = ARB_N,
  parameter int MAX_HOLD  = ARB_MAX_HOLD,
  parameter int TA_CYCLES = ARB_TA
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] drive_low,
  input  logic         bus_in,
  output logic [N-1:0] grant,
  output logic [N-1:0] pd_en,
  output logic         busy,
  output logic         timeout,
  output logic         err_stuck
);

  localparam int IW = idx_w(N);
  localparam int HW = cnt_w(MAX_HOLD);
  localparam int TW = cnt_w(TA_CYCLES);

  localparam logic [1:0] ST_IDLE  = ARB_IDLE;
  localparam logic [1:0] ST_GRANT = ARB_GRANT;
  localparam logic [1:0] ST_TURN  = ARB_TURN;

  logic [1:0]    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] ta_cnt;
  logic [N-1:0]  mask;
  logic          low_prev;

  logic [N-1:0]  eligible;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_req;
  logic          hold_done;
  logic          ta_done;
  logic          force_release;
  logic [IW-1:0] next_ptr;
  logic          low_now;

  assign eligible      = req & ~mask;
  assign owner_req     = req[owner];
  assign hold_done     = (hold_cnt == HW'(MAX_HOLD));
  assign ta_done       = (ta_cnt == TW'(TA_CYCLES));
  // A requester that lets go on its last allowed cycle is a normal release, not a timeout.
  assign force_release = (state == ST_GRANT) && owner_req && hold_done;
  assign next_ptr      = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

  // Only the current owner may ever pull the line; grant is registered so this is glitch-free.
  assign pd_en = grant & drive_low;
  assign busy  = (state == ST_GRANT);
  // Line is low while nobody is allowed to pull it down.
  assign low_now = (pd_en == '0) && !bus_in;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // Ownership FSM: pick in IDLE, hold with bounded count, then a fixed release gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      ta_cnt   <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= pick_onehot;
            owner    <= pick_idx;
            hold_cnt <= HW'(1);
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!owner_req || hold_done) begin
            grant   <= '0;
            rr_ptr  <= next_ptr;
            ta_cnt  <= TW'(1);
            state   <= ST_TURN;
            timeout <= owner_req;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_TURN: begin
          if (ta_done) begin
            state <= ST_IDLE;
          end else begin
            ta_cnt <= ta_cnt + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Penalty mask: a timed-out owner stays ineligible until it drops its request once.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
    end else begin
      mask <= (mask & req) | (force_release ? grant : '0);
    end
  end

  // Stuck-low detector: two consecutive undriven-low samples latch a sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_prev  <= 1'b0;
      err_stuck <= 1'b0;
    end else begin
      low_prev <= low_now;
      if (low_now && low_prev) begin
        err_stuck <= 1'b1;
      end
    end
  end

endmodule
